phys_free_list: RTL

- Rename-stage allocator that sits directly upstream of the general map table.
- Holds a circular queue of free physical register tags.
- Each cycle it hands up to ALLOC_PORTS tags to rename. Those tags feed the map table's write data.
- Each cycle it accepts up to FREE_PORTS tags released at retire.
- Allocation is all-or-nothing per cycle, so rename stalls cleanly when the pool is short.

---
 rtl/phys_free_list.sv | 96 +++++++++
 1 files changed

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags for the rename stage.
// Grants up to ALLOC_PORTS tags per cycle (all-or-nothing) and accepts up to FREE_PORTS releases.
module phys_free_list #(
    parameter int unsigned PHYS_COUNT  = 128,
    parameter int unsigned ARCH_COUNT  = 32,
    parameter int unsigned TAG_WIDTH   = $clog2(PHYS_COUNT),
    parameter int unsigned ALLOC_PORTS = 4,
    parameter int unsigned FREE_PORTS  = 4
) (
    input  logic                                   clk,
    input  logic                                   sync_rst_n,
    input  logic                                   clk_en,
    input  logic [ALLOC_PORTS-1:0]                 alloc_req,
    output logic                                   alloc_grant,
    output logic [ALLOC_PORTS-1:0][TAG_WIDTH-1:0]  alloc_tag,
    input  logic [FREE_PORTS-1:0]                  free_en,
    input  logic [FREE_PORTS-1:0][TAG_WIDTH-1:0]   free_tag,
    output logic [TAG_WIDTH:0]                     free_count,
    output logic                                   overflow_err
);

    localparam int unsigned CW = TAG_WIDTH + 1;
    typedef logic [CW-1:0] cnt_t;

    logic [TAG_WIDTH-1:0] entries [PHYS_COUNT];
    logic [TAG_WIDTH-1:0] head_q, tail_q;
    cnt_t                 count_q;
    logic                 overflow_q;

    cnt_t                 n_req, n_alloc, n_free;
    logic [TAG_WIDTH-1:0] free_idx [FREE_PORTS];
    logic [CW:0]          next_sum;
    logic                 ovf;

    // Compacted read: each requesting port takes the next older tag after lower ports.
    always_comb begin
        n_req = '0;
        for (int unsigned k = 0; k < ALLOC_PORTS; k++) begin
            alloc_tag[k] = entries[head_q + n_req[TAG_WIDTH-1:0]];
            if (alloc_req[k]) begin
                n_req = n_req + cnt_t'(1);
            end
        end
    end

    always_comb begin
        n_free = '0;
        for (int unsigned j = 0; j < FREE_PORTS; j++) begin
            free_idx[j] = tail_q + n_free[TAG_WIDTH-1:0];
            if (free_en[j]) begin
                n_free = n_free + cnt_t'(1);
            end
        end
    end

    assign alloc_grant = clk_en && (count_q >= n_req);

    always_comb begin
        n_alloc  = alloc_grant ? n_req : '0;
        next_sum = {1'b0, count_q} - {1'b0, n_alloc} + {1'b0, n_free};
        ovf      = next_sum > (CW + 1)'(PHYS_COUNT);
    end

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            for (int unsigned i = 0; i < PHYS_COUNT; i++) begin
                if (i < PHYS_COUNT - ARCH_COUNT) begin
                    entries[i] <= TAG_WIDTH'(ARCH_COUNT + i);
                end
            end
            head_q     <= '0;
            tail_q     <= TAG_WIDTH'(PHYS_COUNT - ARCH_COUNT);
            count_q    <= cnt_t'(PHYS_COUNT - ARCH_COUNT);
            overflow_q <= 1'b0;
        end else if (clk_en) begin
            head_q <= TAG_WIDTH'(head_q + n_alloc);
            if (ovf) begin
                // Releases that would overfill are dropped wholesale; allocation still proceeds.
                overflow_q <= 1'b1;
                count_q    <= count_q - n_alloc;
            end else begin
                tail_q  <= TAG_WIDTH'(tail_q + n_free);
                count_q <= count_q - n_alloc + n_free;
                for (int unsigned j = 0; j < FREE_PORTS; j++) begin
                    if (free_en[j]) begin
                        entries[free_idx[j]] <= free_tag[j];
                    end
                end
            end
        end
    end

    assign free_count   = count_q;
    assign overflow_err = overflow_q;

endmodule
